ifu_inst_buffer: RTL

//  Instruction queue between the ifu IF/ID output register and the idu.

---
 rtl/ifu_inst_buffer_pkg.sv | 24 ++
 rtl/ifu_inst_buffer_predecode.sv | 29 ++
 rtl/ifu_inst_buffer.sv | 118 +++++++++++
 3 files changed

// File: rtl/ifu_inst_buffer_pkg.sv
// Shared constants and entry layout for the fetch-to-decode instruction buffer.
package ifu_inst_buffer_pkg;

  localparam int IBUF_DEPTH = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // 122-bit entry: 119 payload bits plus 3 spare at the top
  typedef struct packed {
    logic [2:0]  spare;
    logic        fault;
    logic        is_jalr;
    logic        is_jal;
    logic        is_branch;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [15:0] inst_compress;
    logic [1:0]  rresp;
    logic        compress;
  } ibuf_entry_t;

endpackage

// File: rtl/ifu_inst_buffer_predecode.sv
// Write-path predecode: control-flow tags from the opcode and bus response.
module ibuf_predecode
  import ifu_inst_buffer_pkg::*;
(
  input  logic [6:0] inst,
  input  logic [1:0] rresp,
  output logic       is_branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       fault
);

  always_comb begin
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    fault     = |rresp;
    // a faulted fetch carries garbage, so never tag it as control flow
    if (!fault) begin
      unique case (inst)
        OPC_BRANCH: is_branch = 1'b1;
        OPC_JAL:    is_jal    = 1'b1;
        OPC_JALR:   is_jalr   = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/ifu_inst_buffer.sv
// Instruction queue between the IF/ID register and decode, with predecode tags.
module ifu_inst_buffer
  import ifu_inst_buffer_pkg::*;
#(
  parameter int DEPTH  = IBUF_DEPTH,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_compress_flag,
  input  logic [1:0]        in_rresp,
  input  logic [15:0]       in_inst_compress,
  input  logic [31:0]       in_inst,
  input  logic [63:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_compress_flag,
  output logic [1:0]        out_rresp,
  output logic [15:0]       out_inst_compress,
  output logic [31:0]       out_inst,
  output logic [63:0]       out_pc,
  output logic              out_is_branch,
  output logic              out_is_jal,
  output logic              out_is_jalr,
  output logic              out_fault,
  output logic [ADDR_W:0]   buf_count
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  ibuf_entry_t       r_mem [DEPTH];

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_is_branch;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_fault;
  ibuf_entry_t       w_new;

  assign w_wr_idx = r_wr_ptr[ADDR_W-1:0];
  assign w_rd_idx = r_rd_ptr[ADDR_W-1:0];

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_idx == w_rd_idx) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // readiness depends only on registered state, never on out_ready
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign buf_count = r_wr_ptr - r_rd_ptr;

  ibuf_predecode u_predecode (
    .inst      (in_inst[6:0]),
    .rresp     (in_rresp),
    .is_branch (w_is_branch),
    .is_jal    (w_is_jal),
    .is_jalr   (w_is_jalr),
    .fault     (w_fault)
  );

  always_comb begin
    w_new               = '0;
    w_new.compress      = in_compress_flag;
    w_new.rresp         = in_rresp;
    w_new.inst_compress = in_inst_compress;
    w_new.inst          = in_inst;
    w_new.pc            = in_pc;
    w_new.is_branch     = w_is_branch;
    w_new.is_jal        = w_is_jal;
    w_new.is_jalr       = w_is_jalr;
    w_new.fault         = w_fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // flush leaves storage alone; only the pointers forget it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[w_wr_idx] <= w_new;
    end
  end

  assign out_compress_flag = r_mem[w_rd_idx].compress;
  assign out_rresp         = r_mem[w_rd_idx].rresp;
  assign out_inst_compress = r_mem[w_rd_idx].inst_compress;
  assign out_inst          = r_mem[w_rd_idx].inst;
  assign out_pc            = r_mem[w_rd_idx].pc;
  assign out_is_branch     = r_mem[w_rd_idx].is_branch;
  assign out_is_jal        = r_mem[w_rd_idx].is_jal;
  assign out_is_jalr       = r_mem[w_rd_idx].is_jalr;
  assign out_fault         = r_mem[w_rd_idx].fault;

endmodule
